// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared state encoding and default geometry for the ccff chain loader.
package ccff_loader_pkg;
    localparam int NUM_CHAINS_DEF = 12;
    localparam int CHAIN_LEN_DEF  = 1024;
    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, CHECK, DONE} state_t;
endpackage

// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: valid/ready bitstream word stream, one bit per configuration chain.
interface ccff_chain_loader_if #(
    parameter int NUM_CHAINS = 12
);
    logic                  s_valid;
    logic [NUM_CHAINS-1:0] s_data;
    logic                  s_ready;
    modport master (output s_valid, output s_data, input s_ready);
    modport slave (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams bitstream words into the parallel ccff chains and sequences config_enable.
// Define CCFF_READBACK_EN to build in the word-0 readback self-check driving err.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int NUM_CHAINS = NUM_CHAINS_DEF,
    parameter int CHAIN_LEN  = CHAIN_LEN_DEF,
    parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  prog_clk,
    input  logic                  pReset_n,
    input  logic                  start,
    input  logic                  abort,
    ccff_chain_loader_if.slave    s_if,
    output logic [NUM_CHAINS-1:0] ccff_head,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic                  prog_clk_en,
    output logic                  config_enable,
    output logic                  done,
    output logic                  err
);
    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_CHAINS-1:0] r_head;
    logic                  r_pce;
    logic                  w_acc;
    logic                  w_last;
    logic                  w_go;

    // abort gates acceptance so an aborted cycle never shifts the chains
    assign s_if.s_ready  = (r_state == LOAD) && (r_cnt < CNT_W'(CHAIN_LEN));
    assign w_acc         = s_if.s_valid && s_if.s_ready && !abort;
    assign w_last        = w_acc && (r_cnt == CNT_W'(CHAIN_LEN - 1));
    assign w_go          = start && !abort && (r_state == IDLE || r_state == DONE);
    assign config_enable = (r_state == LOAD) || (r_state == FLUSH) || (r_state == CHECK);
    assign done          = r_state == DONE;
    assign ccff_head     = r_head;
    assign prog_clk_en   = r_pce;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = start ? LOAD : r_state;
            LOAD:       w_next = w_last ? FLUSH : LOAD;
            FLUSH:      w_next = CHECK;
            CHECK:      w_next = DONE;
            default:    w_next = IDLE;
        endcase
        if (abort) w_next = IDLE;
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_head  <= '0;
            r_pce   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pce   <= w_acc;
            if (w_acc) r_head <= s_if.s_data;
            if (w_go) r_cnt <= '0;
            else if (w_acc) r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef CCFF_READBACK_EN
    logic [NUM_CHAINS-1:0] r_word0;
    logic                  r_err;

    // word 0 travels farthest, so after the final shift it sits at the tails
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_word0 <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_acc && r_cnt == '0) r_word0 <= s_if.s_data;
            if (abort || w_go) r_err <= 1'b0;
            else if (r_state == CHECK) r_err <= ccff_tail != r_word0;
        end
    end

    assign err = r_err;
`else
    logic w_unused_tail;
    assign w_unused_tail = ^ccff_tail;
    assign err           = 1'b0;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: table-driven loads against a 12x8 chain model with a pulse/word scoreboard.
module tb_ccff_chain_loader;
    localparam int NC = 12;
    localparam int CL = 8;

    typedef struct {
        logic [NC-1:0] w0;
        logic [3:0]    vpat;
        bit            flip;
        bit            rst_flush;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [NC-1:0] ccff_head;
    logic [NC-1:0] ccff_tail;
    logic          prog_clk_en;
    logic          config_enable;
    logic          done;
    logic          err;
    logic [NC-1:0] chain [CL];
    logic [NC-1:0] q [$];
    bit            flip_r;
    int            n_vec = 0;
    int            n_err = 0;
    int            n_pulse = 0;
    vec_t          tbl [6];

    ccff_chain_loader_if #(.NUM_CHAINS(NC)) sif ();

    ccff_chain_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL)) dut (
        .prog_clk      (clk),
        .pReset_n      (rst_n),
        .start         (start),
        .abort         (abort),
        .s_if          (sif.slave),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .prog_clk_en   (prog_clk_en),
        .config_enable (config_enable),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    // fabric model: chains shift only on gated prog_clk edges
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CL; k++) chain[k] <= '0;
        end else if (prog_clk_en) begin
            for (int k = CL - 1; k > 0; k--) chain[k] <= chain[k-1];
            chain[0] <= ccff_head;
        end
    end

    assign ccff_tail = chain[CL-1] ^ (flip_r ? 12'h008 : 12'h000);

    task automatic chk(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && prog_clk_en) begin
            n_pulse++;
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pulse: unexpected prog_clk_en with head %h, expected none", ccff_head);
            end else begin
                chk("pulse_head", ccff_head, q.pop_front());
            end
        end
    end

    task automatic load(input vec_t v);
        int idx = 0;
        int cyc = 0;
        bit acc;
        bit exp_err;
`ifdef CCFF_READBACK_EN
        exp_err = v.flip;
`else
        exp_err = 1'b0;
`endif
        flip_r  = v.flip;
        n_pulse = 0;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_cfg_en", NC'(config_enable), 12'h001);
        chk("start_ready", NC'(sif.s_ready), 12'h001);
        chk("start_done", NC'(done), 12'h000);
        chk("start_err", NC'(err), 12'h000);
        while (idx < CL && cyc < 100) begin
            sif.s_valid = v.vpat[cyc % 4];
            sif.s_data  = (idx == 0) ? v.w0 : NC'(idx + 1);
            acc = sif.s_valid && sif.s_ready;
            if (acc) q.push_back(sif.s_data);
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
            if (idx < CL) chk("load_cfg_en", NC'(config_enable), 12'h001);
        end
        sif.s_valid = 1'b0;
        if (idx < CL) chk("load_timeout", NC'(idx), NC'(CL));
        chk("flush_ready", NC'(sif.s_ready), 12'h000);
        chk("flush_done", NC'(done), 12'h000);
        if (v.rst_flush) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_head", ccff_head, 12'h000);
            chk("rst_pce", NC'(prog_clk_en), 12'h000);
            chk("rst_cfg_en", NC'(config_enable), 12'h000);
            chk("rst_ready", NC'(sif.s_ready), 12'h000);
            chk("rst_done_err", NC'({done, err}), 12'h000);
            q.delete();
            @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (3) begin
                @(posedge clk);
                #1;
                chk("post_rst_idle", NC'({config_enable, sif.s_ready, done, prog_clk_en}), 12'h000);
            end
            return;
        end
        @(posedge clk);
        #1;
        chk("check_done", NC'(done), 12'h000);
        chk("check_cfg_en", NC'(config_enable), 12'h001);
        @(posedge clk);
        #1;
        chk("done", NC'(done), 12'h001);
        chk("err", NC'(err), NC'(exp_err));
        chk("done_cfg_en", NC'(config_enable), 12'h000);
        chk("pulses", NC'(n_pulse), NC'(CL));
        chk("queue_empty", NC'(q.size()), 12'h000);
        @(posedge clk);
        #1;
        chk("done_held", NC'({done, err}), NC'({1'b1, exp_err}));
        chk("done_pce", NC'(prog_clk_en), 12'h000);
    endtask

    initial begin
        tbl[0] = '{w0: 12'h001, vpat: 4'b1111, flip: 1'b0, rst_flush: 1'b0};
        tbl[1] = '{w0: 12'h001, vpat: 4'b1001, flip: 1'b0, rst_flush: 1'b0};
        tbl[2] = '{w0: 12'hA5A, vpat: 4'b1111, flip: 1'b0, rst_flush: 1'b0};
        tbl[3] = '{w0: 12'hA5A, vpat: 4'b1111, flip: 1'b1, rst_flush: 1'b0};
        tbl[4] = '{w0: 12'h3C3, vpat: 4'b0101, flip: 1'b0, rst_flush: 1'b0};
        tbl[5] = '{w0: 12'h5F0, vpat: 4'b1111, flip: 1'b0, rst_flush: 1'b1};
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        flip_r      = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        #12;
        chk("reset_head", ccff_head, 12'h000);
        chk("reset_outs", NC'({sif.s_ready, prog_clk_en, config_enable, done, err}), 12'h000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) load(tbl[i]);
        // abort after four accepted words, then a clean reload
        flip_r = 1'b0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sif.s_valid = 1'b1;
            sif.s_data  = NC'(12'h100 + i);
            q.push_back(sif.s_data);
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        start = 1'b1;
        sif.s_data = 12'hFFF;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        sif.s_valid = 1'b0;
        chk("abort_cfg_en", NC'(config_enable), 12'h000);
        chk("abort_ready", NC'(sif.s_ready), 12'h000);
        chk("abort_done", NC'(done), 12'h000);
        chk("abort_pce", NC'(prog_clk_en), 12'h000);
        load(tbl[0]);
        load(tbl[3]);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
